// File: rtl/jk_cmd_pkg.sv
// Shared types for the JK command driver: op encoding, FSM states and J/K decode.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE
  } jk_state_e;

  // Returns {J, K} for an op.
  function automatic logic [1:0] jk_decode(input jk_op_e op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Next Q of a JK flop given the op and the current Q.
  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic [1:0] jk;
    jk = jk_decode(op);
    return (jk[1] & ~q) | (~jk[0] & q);
  endfunction

endpackage

// File: rtl/jk_cmd_driver_if.sv
// Command handshake bundle between a command source and jk_cmd_driver.
interface jk_cmd_driver_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_ref_model.sv
// Reference copy of the flop's Q, advanced on every CE cycle and checked on settle.
module jk_ref_model
  import jk_cmd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   upd,
  input  logic   check,
  input  jk_op_e op,
  input  logic   qin,
  output logic   exp_q,
  output logic   err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (upd) exp_q <= jk_next(op, exp_q);
      if (check && (qin != exp_q)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// Sequencer producing J/K/CE bursts for a JK flop from a valid/ready command stream.
// Define JK_CMD_CHECK_EN to compile in the Q reference model and the sticky err flag.
module jk_cmd_driver
  import jk_cmd_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  R,
  jk_cmd_driver_if.slave        cmd,
  output logic                  J,
  output logic                  K,
  output logic                  CE,
  input  logic                  Qin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  jk_state_e        state;
  logic [CNT_W-1:0] cnt;
  jk_op_e           op_q;

  // cmd_ready is a register so it stays low through reset and rises one edge after release.
  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      op_q          <= OP_HOLD;
      cmd.cmd_ready <= 1'b0;
      J             <= 1'b0;
      K             <= 1'b0;
      CE            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_ready && cmd.cmd_valid) begin
            op_q          <= jk_op_e'(cmd.cmd_op);
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (cmd.cmd_len != '0) begin
              state    <= ST_DRIVE;
              cnt      <= cmd.cmd_len;
              CE       <= 1'b1;
              {J, K}   <= jk_decode(jk_op_e'(cmd.cmd_op));
            end else begin
              state <= ST_SETTLE;
              done  <= 1'b1;
            end
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == CNT_W'(1)) begin
            state  <= ST_SETTLE;
            cnt    <= '0;
            CE     <= 1'b0;
            {J, K} <= 2'b00;
            done   <= 1'b1;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            {J, K} <= jk_decode(op_q);
          end
        end
        ST_SETTLE: begin
          state         <= ST_IDLE;
          done          <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JK_CMD_CHECK_EN
  logic exp_q;

  // CE is high exactly in DRIVE and done exactly in SETTLE, so they serve as update/check strobes.
  jk_ref_model u_ref (
    .clk   (Clk),
    .rst   (R),
    .upd   (CE),
    .check (done),
    .op    (op_q),
    .qin   (Qin),
    .exp_q (exp_q),
    .err   (err)
  );
`else
  logic unused_qin;
  assign unused_qin = Qin;
  assign err        = 1'b0;
`endif

endmodule
